// File: rtl/wb_rr_arb.sv
// Round-robin Wishbone arbiter: NMAST masters share one slave port, with a
// one-cycle arbitration step, a dead cycle between grants and a watchdog.
module wb_rr_arb #(
    parameter int          NMAST   = 4,
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] TO_DATA = 32'hDEADBEEF
) (
    input  logic                     wb_clk,
    input  logic                     wb_rst,
    input  logic [NMAST-1:0]         m_cyc,
    input  logic [NMAST*32-1:0]      m_adr,
    input  logic [NMAST-1:0]         m_we,
    input  logic [NMAST*4-1:0]       m_sel,
    input  logic [NMAST*32-1:0]      m_dat,
    output logic [NMAST-1:0]         m_ack,
    output logic [31:0]              m_rdt,
    output logic                     x_cyc,
    output logic [31:0]              x_adr,
    output logic                     x_we,
    output logic [3:0]               x_sel,
    output logic [31:0]              x_dat,
    input  logic                     x_ack,
    input  logic [31:0]              x_rdt,
    output logic                     busy,
    output logic [$clog2(NMAST)-1:0] grant,
    output logic                     timeout
);

    localparam int GW = $clog2(NMAST);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Handshake: a master request is live while m_cyc is high; the access
    // completes in the cycle m_ack is high (slave ack or watchdog expiry).
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_d;
    logic [GW-1:0]   next_grant;
    logic [TW-1:0]   timer_q, timer_d;
    logic            expire;

    logic [31:0]     adr_a [NMAST];
    logic [31:0]     dat_a [NMAST];
    logic [3:0]      sel_a [NMAST];

    always_comb begin
        for (int i = 0; i < NMAST; i++) begin
            adr_a[i] = m_adr[32*i +: 32];
            dat_a[i] = m_dat[32*i +: 32];
            sel_a[i] = m_sel[4*i +: 4];
        end
    end

    // Scan from the farthest offset down so the nearest requester after grant wins.
    always_comb begin
        int idx;
        idx        = 0;
        next_grant = grant;
        for (int i = NMAST; i >= 1; i--) begin
            idx = int'(grant) + i;
            if (idx >= NMAST) idx = idx - NMAST;
            if (m_cyc[idx[GW-1:0]]) next_grant = idx[GW-1:0];
        end
    end

    assign expire = (timer_q == TW'(TIMEOUT - 1));
    assign busy   = (state_q == BUSY);

    always_comb begin
        state_d = state_q;
        grant_d = grant;
        timer_d = timer_q;
        x_cyc   = 1'b0;
        x_adr   = '0;
        x_we    = 1'b0;
        x_sel   = '0;
        x_dat   = '0;
        m_ack   = '0;
        m_rdt   = '0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (|m_cyc) begin
                    grant_d = next_grant;
                    timer_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                x_adr = adr_a[grant];
                x_we  = m_we[grant];
                x_sel = sel_a[grant];
                x_dat = dat_a[grant];
                // x_cyc must not depend on x_ack, so expiry forces it low unconditionally.
                x_cyc = m_cyc[grant] && !expire;
                if (x_ack) begin
                    m_ack[grant] = 1'b1;
                    m_rdt        = x_rdt;
                    state_d      = IDLE;
                end else if (!m_cyc[grant]) begin
                    state_d = IDLE;
                end else if (expire) begin
                    m_ack[grant] = 1'b1;
                    m_rdt        = TO_DATA;
                    timeout      = 1'b1;
                    state_d      = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= IDLE;
            grant   <= GW'(NMAST - 1);
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_arb.sv
// Bench for wb_rr_arb: directed scenarios then random traffic, every cycle
// compared against a transaction-level round-robin model.
module tb_wb_rr_arb;

    localparam int          NM  = 4;
    localparam int          TO  = 4;
    localparam logic [31:0] TOD = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          wb_rst;
    logic [NM-1:0] cyc;
    logic [31:0]   adr [NM];
    logic [31:0]   dat [NM];
    logic [3:0]    sel [NM];
    logic [NM-1:0] we;
    logic [NM*32-1:0] m_adr, m_dat;
    logic [NM*4-1:0]  m_sel;
    logic [NM-1:0] m_ack;
    logic [31:0]   m_rdt, x_adr, x_dat, x_rdt;
    logic          x_cyc, x_we, x_ack, busy, timeout;
    logic [3:0]    x_sel;
    logic [1:0]    grant;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: who owns the bus, whether a transfer is open, and its age
    bit            mdl_busy;
    int            mdl_owner;
    int            mdl_age;
    logic [NM-1:0] last_ack;
    logic [31:0]   last_rdt;
    logic [1:0]    last_grant;
    logic          last_to;
    logic [31:0]   exp_q [$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            m_adr[32*i +: 32] = adr[i];
            m_dat[32*i +: 32] = dat[i];
            m_sel[4*i +: 4]   = sel[i];
        end
    end

    wb_rr_arb #(.NMAST(NM), .TIMEOUT(TO), .TO_DATA(TOD)) dut (
        .wb_clk(clk), .wb_rst(wb_rst),
        .m_cyc(cyc), .m_adr(m_adr), .m_we(we), .m_sel(m_sel), .m_dat(m_dat),
        .m_ack(m_ack), .m_rdt(m_rdt),
        .x_cyc(x_cyc), .x_adr(x_adr), .x_we(x_we), .x_sel(x_sel), .x_dat(x_dat),
        .x_ack(x_ack), .x_rdt(x_rdt),
        .busy(busy), .grant(grant), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        mdl_busy  = 1'b0;
        mdl_owner = NM - 1;
        mdl_age   = 0;
    endtask

    // Check all outputs mid-cycle against the model, then advance one clock.
    task automatic tick();
        logic [NM-1:0] e_ack;
        logic [31:0]   e_rdt, e_adr, e_dat;
        logic [3:0]    e_sel;
        logic          e_xcyc, e_we, e_to, n_busy, found;
        int            n_owner, n_age, cand;
        #2;
        e_ack = '0; e_rdt = '0; e_adr = '0; e_dat = '0; e_sel = '0;
        e_xcyc = 1'b0; e_we = 1'b0; e_to = 1'b0; found = 1'b0;
        n_busy = mdl_busy; n_owner = mdl_owner; n_age = mdl_age;
        if (!mdl_busy) begin
            for (int k = 1; k <= NM; k++) begin
                cand = (mdl_owner + k) % NM;
                if (!found && cyc[cand]) begin
                    found   = 1'b1;
                    n_owner = cand;
                    n_busy  = 1'b1;
                    n_age   = 0;
                end
            end
        end else begin
            e_adr  = adr[mdl_owner];
            e_dat  = dat[mdl_owner];
            e_sel  = sel[mdl_owner];
            e_we   = we[mdl_owner];
            e_xcyc = cyc[mdl_owner] && (mdl_age != TO - 1);
            if (x_ack) begin
                e_ack[mdl_owner] = 1'b1;
                e_rdt  = x_rdt;
                n_busy = 1'b0;
            end else if (!cyc[mdl_owner]) begin
                n_busy = 1'b0;
            end else if (mdl_age == TO - 1) begin
                e_ack[mdl_owner] = 1'b1;
                e_rdt  = TOD;
                e_to   = 1'b1;
                n_busy = 1'b0;
            end else begin
                n_age = mdl_age + 1;
            end
        end
        chk("busy",    32'(busy),    32'(mdl_busy));
        chk("grant",   32'(grant),   32'(mdl_owner));
        chk("x_cyc",   32'(x_cyc),   32'(e_xcyc));
        chk("m_ack",   32'(m_ack),   32'(e_ack));
        chk("m_rdt",   m_rdt,        e_rdt);
        chk("timeout", 32'(timeout), 32'(e_to));
        chk("x_adr",   x_adr,        e_adr);
        chk("x_dat",   x_dat,        e_dat);
        chk("x_sel",   32'(x_sel),   32'(e_sel));
        chk("x_we",    32'(x_we),    32'(e_we));
        last_ack = m_ack; last_rdt = m_rdt; last_grant = grant; last_to = timeout;
        @(posedge clk);
        #1;
        mdl_busy = n_busy; mdl_owner = n_owner; mdl_age = n_age;
    endtask

    initial begin
        int served, cnt;
        wb_rst = 1'b1; cyc = '0; we = '0; x_ack = 1'b0; x_rdt = '0;
        for (int i = 0; i < NM; i++) begin
            adr[i] = '0; dat[i] = '0; sel[i] = '0;
        end
        model_reset();
        #1;
        chk("rst_grant", 32'(grant), 32'(NM - 1));
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_xcyc",  32'(x_cyc), 32'd0);
        chk("rst_ack",   32'(m_ack), 32'd0);
        @(posedge clk);
        #1;
        wb_rst = 1'b0;

        // all four masters request continuously; slave acks on the 2nd busy cycle
        for (int i = 0; i < NM; i++) begin
            adr[i] = 32'h1000 * (i + 1); sel[i] = 4'hF;
        end
        exp_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        cyc = 4'hF; served = 0;
        for (int c = 0; c < 40 && served < 5; c++) begin
            x_ack = mdl_busy && (mdl_age == 1);
            x_rdt = $urandom;
            tick();
            if (|last_ack) begin
                chk("rr_order", 32'(last_grant), exp_q.pop_front());
                served++;
            end
        end
        chk("rr_served", 32'(served), 32'd5);
        cyc = '0; x_ack = 1'b0;
        tick();

        // write on master 1 while masters 0 and 3 wait
        adr[1] = 32'h2000; we[1] = 1'b1; sel[1] = 4'b0011; dat[1] = 32'hCAFEF00D;
        cyc = 4'b1011; cnt = 0;
        for (int c = 0; c < 20 && !last_ack[1]; c++) begin
            x_ack = mdl_busy && (mdl_owner == 1) && (mdl_age == 2);
            tick();
            cnt++;
        end
        chk("wr_ack", 32'(last_ack), 32'b0010);
        chk("wr_cycles", 32'(cnt), 32'd4);
        cyc = '0; x_ack = 1'b0; we = '0;
        tick();

        // single read from master 2, ack on the third busy cycle
        adr[2] = 32'h100; cyc = 4'b0100;
        tick(); tick(); tick();
        x_ack = 1'b1; x_rdt = 32'h12345678;
        tick();
        chk("rd_ack", 32'(last_ack), 32'b0100);
        chk("rd_rdt", last_rdt, 32'h12345678);
        chk("rd_grant", 32'(last_grant), 32'd2);
        x_ack = 1'b0; cyc = '0;
        tick();

        // slave never acks: watchdog expires on the fourth busy cycle
        cyc = 4'b1100; cnt = 0; last_to = 1'b0;
        for (int c = 0; c < 10 && !last_to; c++) begin
            tick();
            cnt++;
        end
        chk("to_pulse", 32'(last_to), 32'd1);
        chk("to_cycles", 32'(cnt), 32'd5);
        chk("to_rdt", last_rdt, TOD);
        cyc = 4'b0100;
        tick(); tick();
        x_ack = 1'b1;
        tick();
        x_ack = 1'b0; cyc = '0;
        tick();

        // master 0 aborts after two busy cycles; master 1 is served next
        cyc = 4'b0011;
        tick(); tick(); tick();
        cyc = 4'b0010;
        tick();
        chk("abort_ack", 32'(last_ack), 32'd0);
        tick(); tick();
        x_ack = 1'b1;
        tick();
        chk("abort_next", 32'(last_ack), 32'b0010);
        x_ack = 1'b0; cyc = '0;
        tick();

        // asynchronous reset while master 3 owns the bus with an ack in flight
        cyc = 4'b1000;
        tick(); tick();
        x_ack = 1'b1;
        wb_rst = 1'b1;
        #1;
        chk("arst_xcyc", 32'(x_cyc),   32'd0);
        chk("arst_ack",  32'(m_ack),   32'd0);
        chk("arst_busy", 32'(busy),    32'd0);
        chk("arst_to",   32'(timeout), 32'd0);
        chk("arst_grant", 32'(grant),  32'd3);
        @(posedge clk);
        #1;
        wb_rst = 1'b0; x_ack = 1'b0; model_reset();
        cyc = 4'b1010;
        tick(); tick();
        chk("arst_first", 32'(last_grant), 32'd1);
        x_ack = 1'b1;
        tick();
        x_ack = 1'b0; cyc = '0;
        tick();

        // random traffic: masters raise/abort at random, slave acks at random
        last_ack = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (cyc[i] && last_ack[i]) begin
                    cyc[i] = 1'b0;
                end else if (!cyc[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        cyc[i] = 1'b1;
                        adr[i] = $urandom; dat[i] = $urandom;
                        sel[i] = 4'($urandom_range(0, 15));
                        we[i]  = 1'($urandom_range(0, 1));
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    cyc[i] = 1'b0;
                end
            end
            x_ack = mdl_busy && cyc[mdl_owner] && ($urandom_range(0, 2) == 0);
            x_rdt = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_rr_arb.md
Name: wb_rr_arb

Overview:
- Round-robin Wishbone arbiter that shares one slave port (SRAM, ROM or peripheral bus) between NMAST bus masters, e.g. the SERV iBus/dBus plus a DMA or debug master.
- Supports reads and writes (we/sel/dat).
- A grant is held until the slave acks, the master drops cyc, or a watchdog times out.
- Sits between the masters and the existing slave-side decode.

Parameters:
NMAST, 4, number of requesting masters (2..8)
TIMEOUT, 255, BUSY cycles without x_ack before forced termination (must be >= 1; counter width = clog2(TIMEOUT+1))
TO_DATA, 32'hDEADBEEF, read data returned to a master on timeout

Ports:
wb_clk  in  1  clock
wb_rst  in  1  asynchronous active-high reset
m_cyc  in  NMAST  per-master cycle request
m_adr  in  NMAST*32  per-master address, master i at [32*i+31:32*i]
m_we  in  NMAST  per-master write enable
m_sel  in  NMAST*4  per-master byte selects
m_dat  in  NMAST*32  per-master write data
m_ack  out  NMAST  per-master ack, one-hot or zero
m_rdt  out  32  shared read data, valid with m_ack
x_cyc  out  1  slave cycle
x_adr  out  32  slave address
x_we  out  1  slave write enable
x_sel  out  4  slave byte selects
x_dat  out  32  slave write data
x_ack  in  1  slave ack
x_rdt  in  32  slave read data
busy  out  1  arbiter in BUSY state
grant  out  clog2(NMAST)  index of current or last owner
timeout  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (async, wb_rst=1): state=IDLE, grant=NMAST-1 (so master 0 has first priority), timer=0, all outputs 0.
- State IDLE: if any m_cyc is high, select the first requester searching from grant+1 modulo NMAST, wrapping. Register it into grant and go to BUSY. No output is driven in IDLE.
- Arbitration latency: 1 cycle from m_cyc high to x_cyc high.
- State BUSY:
  - x_cyc = m_cyc[grant].
  - x_adr/x_we/x_sel/x_dat = the grant master's fields, combinational mux.
  - All other masters stall; their m_ack stays 0.
- x_ack in BUSY:
  - m_ack[grant] = 1 in the same cycle (combinational pass-through) and m_rdt = x_rdt.
  - Next state IDLE. This guarantees one dead cycle between grants, so the master can drop cyc.
- Master abort (m_cyc[grant]=0 in BUSY, no x_ack): x_cyc=0, next state IDLE, no ack to any master.
- Watchdog, counting:
  - timer clears on entry to BUSY and increments each BUSY cycle without x_ack.
- Watchdog, expiry (timer == TIMEOUT-1 and no x_ack):
  - m_ack[grant]=1, m_rdt=TO_DATA, timeout=1 for that cycle, x_cyc forced 0, next state IDLE.
  - x_ack in that same cycle has priority: normal completion, no timeout pulse.
- m_rdt when no ack: 0.
- busy = (state==BUSY).
- Fairness: after master k is served, every other master still requesting is served before k again. Worst-case wait is (NMAST-1) transactions.
- A late m_cyc rise from a higher-priority master never pre-empts a BUSY grant.
- Any m_cyc change in the IDLE cycle is sampled in that cycle only.
- Reset mid-transaction: immediate return to IDLE. x_cyc and m_ack drop asynchronously, and any in-flight slave ack is ignored.
- No combinational path from x_ack to x_cyc. x_cyc depends only on state, grant and m_cyc, and the state register updates only on the clock.

Test Plan:
- Single master 2 read: m_cyc[2]=1 adr=0x100, slave acks 3 cycles after x_cyc with x_rdt=0x12345678 -> x_cyc rises 1 cycle after m_cyc; m_ack=4'b0100 for exactly 1 cycle with m_rdt=0x12345678; grant=2.
- All four masters request continuously, slave acks each access after 1 cycle -> grant order 0,1,2,3,0 with one idle cycle between grants. Each master gets exactly one ack per 4 transactions.
- Write on master 1 with adr=0x2000, we=1, sel=4'b0011, dat=0xCAFEF00D -> x_adr/x_we/x_sel/x_dat match exactly while x_cyc=1. Masters 0 and 3 requesting concurrently see no ack until master 1 is acked.
- Slave never acks, TIMEOUT=4 -> after 4 BUSY cycles: m_ack[grant]=1, m_rdt=0xDEADBEEF, timeout pulse=1, x_cyc=0. Next requester is granted after one IDLE cycle.
- Master 0 drops m_cyc after 2 BUSY cycles without ack -> x_cyc=0 in the same cycle, no m_ack, arbiter returns to IDLE and grants the next pending master.
- Assert wb_rst while BUSY (master 3 granted) -> x_cyc, m_ack, busy and timeout go 0 without a clock edge. After release, the first grant goes to the lowest requesting index.
